// File: rtl/axis_rx_checker.sv
// AXI4-Stream receive checker: sinks frames, verifies an incrementing-word
// payload, tkeep legality and frame length, keeps saturating statistics and
// drives tready either continuously or with a periodic throttle.
module axis_rx_checker #(
   parameter int AXIS_DATA_WIDTH = 64,
   parameter int CNT_WIDTH       = 32,
   parameter int LEN_WIDTH       = 16,
   parameter int READY_MODE      = 0,
   parameter int READY_PERIOD    = 8
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         cfg_en,
   input  logic [LEN_WIDTH-1:0]         cfg_frame_beats,
   input  logic                         stat_clear,
   input  logic [AXIS_DATA_WIDTH-1:0]   rx_axis_tdata,
   input  logic [AXIS_DATA_WIDTH/8-1:0] rx_axis_tkeep,
   input  logic                         rx_axis_tvalid,
   input  logic                         rx_axis_tlast,
   output logic                         rx_axis_tready,
   output logic [CNT_WIDTH-1:0]         frame_cnt,
   output logic [CNT_WIDTH-1:0]         err_frame_cnt,
   output logic [CNT_WIDTH-1:0]         byte_cnt,
   output logic [LEN_WIDTH-1:0]         last_frame_beats,
   output logic                         err_pulse,
   output logic                         err_sticky
);

   localparam int KW = AXIS_DATA_WIDTH / 8;
   localparam int CW = $clog2(KW + 1);
   localparam int PW = $clog2(READY_PERIOD);
   localparam int SW = CNT_WIDTH + 1;
   localparam logic [PW-1:0] THR_LAST = PW'(READY_PERIOD - 1);
   localparam logic          THROTTLE = (READY_MODE != 0);

   typedef enum logic {S_IDLE = 1'b0, S_BODY = 1'b1} state_t;

   state_t                       r_state;
   logic [AXIS_DATA_WIDTH-1:0]   r_seed;
   logic [LEN_WIDTH-1:0]         r_beat_idx;
   logic                         r_frame_err;
   logic [PW-1:0]                r_thr_cnt;
   logic                         r_tready;
   logic [CNT_WIDTH-1:0]         r_frame_cnt;
   logic [CNT_WIDTH-1:0]         r_err_frame_cnt;
   logic [CNT_WIDTH-1:0]         r_byte_cnt;
   logic [LEN_WIDTH-1:0]         r_last_frame_beats;
   logic                         r_err_pulse;
   logic                         r_err_sticky;

   logic                         w_xfer;
   logic                         w_first;
   logic [AXIS_DATA_WIDTH-1:0]   w_expect;
   logic [KW-1:0]                w_lane_err;
   logic                         w_data_err;
   logic [KW-1:0]                w_keep_plus;
   logic                         w_keep_last_ok;
   logic                         w_keep_err;
   logic [LEN_WIDTH-1:0]         w_total;
   logic                         w_len_err;
   logic                         w_frame_bad;
   logic [CW-1:0]                w_popcnt;
   logic [SW-1:0]                w_byte_sum;

   assign w_xfer   = rx_axis_tvalid & r_tready;
   assign w_first  = (r_state == S_IDLE);
   // Expected word wraps naturally modulo 2^AXIS_DATA_WIDTH.
   assign w_expect = r_seed + AXIS_DATA_WIDTH'(r_beat_idx);

   // Per-lane data compare, masked by tkeep.
   for (genvar gi = 0; gi < KW; gi++) begin : g_lane
      assign w_lane_err[gi] = rx_axis_tkeep[gi] &
                              (rx_axis_tdata[8*gi +: 8] != w_expect[8*gi +: 8]);
   end

   // The first beat only provides the seed, so it is never compared.
   assign w_data_err     = !w_first & (|w_lane_err);
   // A last-beat keep is legal when nonzero and of the form 0..01..1,
   // i.e. adding one clears every set bit.
   assign w_keep_plus    = rx_axis_tkeep + KW'(1);
   assign w_keep_last_ok = (|rx_axis_tkeep) & ((rx_axis_tkeep & w_keep_plus) == '0);
   assign w_keep_err     = rx_axis_tlast ? !w_keep_last_ok : !(&rx_axis_tkeep);
   // Beats seen including the current one; beat_idx already saturates.
   assign w_total        = w_first ? LEN_WIDTH'(1) :
                           ((&r_beat_idx) ? r_beat_idx : r_beat_idx + LEN_WIDTH'(1));
   assign w_len_err      = (cfg_frame_beats != '0) & (w_total != cfg_frame_beats);
   assign w_frame_bad    = (!w_first & r_frame_err) | w_data_err | w_keep_err |
                           (rx_axis_tlast & w_len_err);

   // Count enabled byte lanes of the current beat.
   always_comb begin
      w_popcnt = '0;
      for (int i = 0; i < KW; i++) begin
         w_popcnt = w_popcnt + CW'(rx_axis_tkeep[i]);
      end
   end

   assign w_byte_sum = {1'b0, r_byte_cnt} + SW'(w_popcnt);

   // Free-running throttle phase counter, 0..READY_PERIOD-1.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_thr_cnt <= '0;
      end else if (r_thr_cnt == THR_LAST) begin
         r_thr_cnt <= '0;
      end else begin
         r_thr_cnt <= r_thr_cnt + PW'(1);
      end
   end

   // Registered tready: follows cfg_en, dropped for one phase when throttling.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_tready <= 1'b0;
      end else begin
         r_tready <= cfg_en & (!THROTTLE | (r_thr_cnt != THR_LAST));
      end
   end

   // Frame FSM with seed capture, beat index and accumulated frame error.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_seed      <= '0;
         r_beat_idx  <= '0;
         r_frame_err <= 1'b0;
      end else if (w_xfer) begin
         if (w_first) begin
            r_seed <= rx_axis_tdata;
         end
         r_beat_idx  <= w_total;
         r_frame_err <= rx_axis_tlast ? 1'b0 : w_frame_bad;
         r_state     <= rx_axis_tlast ? S_IDLE : S_BODY;
      end
   end

   // Saturating statistics and error reporting; clear takes priority.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_frame_cnt        <= '0;
         r_err_frame_cnt    <= '0;
         r_byte_cnt         <= '0;
         r_last_frame_beats <= '0;
         r_err_pulse        <= 1'b0;
         r_err_sticky       <= 1'b0;
      end else begin
         r_err_pulse <= w_xfer & rx_axis_tlast & w_frame_bad;
         if (stat_clear) begin
            r_frame_cnt        <= '0;
            r_err_frame_cnt    <= '0;
            r_byte_cnt         <= '0;
            r_last_frame_beats <= '0;
            r_err_sticky       <= 1'b0;
         end else if (w_xfer) begin
            r_byte_cnt <= w_byte_sum[CNT_WIDTH] ? '1 : w_byte_sum[CNT_WIDTH-1:0];
            if (rx_axis_tlast) begin
               r_last_frame_beats <= w_total;
               if (!(&r_frame_cnt)) begin
                  r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
               end
               if (w_frame_bad) begin
                  r_err_sticky <= 1'b1;
                  if (!(&r_err_frame_cnt)) begin
                     r_err_frame_cnt <= r_err_frame_cnt + CNT_WIDTH'(1);
                  end
               end
            end
         end
      end
   end

   assign rx_axis_tready   = r_tready;
   assign frame_cnt        = r_frame_cnt;
   assign err_frame_cnt    = r_err_frame_cnt;
   assign byte_cnt         = r_byte_cnt;
   assign last_frame_beats = r_last_frame_beats;
   assign err_pulse        = r_err_pulse;
   assign err_sticky       = r_err_sticky;

endmodule

// File: tb/tb_axis_rx_checker.sv
// Bench for axis_rx_checker: one continuous-ready instance and one throttled
// instance, with a scoreboard of per-frame expectations checked at each tlast.
module tb_axis_rx_checker;

   logic        clk = 1'b0;
   logic        rstn;
   logic        en[2];
   logic [15:0] cfgb[2];
   logic        clr[2];
   logic [63:0] tdata[2];
   logic [7:0]  tkeep[2];
   logic        tvalid[2];
   logic        tlast[2];
   logic        ready[2];
   logic [31:0] fcnt[2];
   logic [31:0] ecnt[2];
   logic [31:0] bcnt[2];
   logic [15:0] lfb[2];
   logic        pulse[2];
   logic        sticky[2];

   always #5 clk = ~clk;

   axis_rx_checker u_dut0 (
      .clk(clk), .rstn(rstn), .cfg_en(en[0]), .cfg_frame_beats(cfgb[0]),
      .stat_clear(clr[0]), .rx_axis_tdata(tdata[0]), .rx_axis_tkeep(tkeep[0]),
      .rx_axis_tvalid(tvalid[0]), .rx_axis_tlast(tlast[0]), .rx_axis_tready(ready[0]),
      .frame_cnt(fcnt[0]), .err_frame_cnt(ecnt[0]), .byte_cnt(bcnt[0]),
      .last_frame_beats(lfb[0]), .err_pulse(pulse[0]), .err_sticky(sticky[0])
   );

   axis_rx_checker #(.READY_MODE(1), .READY_PERIOD(4)) u_dut1 (
      .clk(clk), .rstn(rstn), .cfg_en(en[1]), .cfg_frame_beats(cfgb[1]),
      .stat_clear(clr[1]), .rx_axis_tdata(tdata[1]), .rx_axis_tkeep(tkeep[1]),
      .rx_axis_tvalid(tvalid[1]), .rx_axis_tlast(tlast[1]), .rx_axis_tready(ready[1]),
      .frame_cnt(fcnt[1]), .err_frame_cnt(ecnt[1]), .byte_cnt(bcnt[1]),
      .last_frame_beats(lfb[1]), .err_pulse(pulse[1]), .err_sticky(sticky[1])
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      int          u;
      logic        err;
      logic [15:0] beats;
      logic        clr;
   } exp_t;

   exp_t sb[$];
   logic acc[2] = '{1'b0, 1'b0};
   int   n_pulse[2] = '{0, 0};
   int   cyc = 0;

   // Bench model of the statistics.
   int   m_frames[2] = '{0, 0};
   int   m_errs[2]   = '{0, 0};
   int   m_bytes[2]  = '{0, 0};
   logic m_sticky[2] = '{1'b0, 1'b0};

   // Note which instances accept a tlast beat on this edge; count pulses.
   always @(posedge clk) begin
      cyc++;
      for (int u = 0; u < 2; u++) begin
         acc[u] <= tvalid[u] & ready[u] & tlast[u];
         if (pulse[u]) n_pulse[u]++;
      end
   end

   // Scoreboard: on the cycle after each tlast transfer, pop and compare.
   always @(negedge clk) begin
      exp_t e;
      for (int u = 0; u < 2; u++) begin
         if (acc[u]) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("sb_unit", 64'(u), 64'(e.u));
               chk("err_pulse", 64'(pulse[u]), 64'(e.err));
               chk("last_frame_beats", 64'(lfb[u]), e.clr ? 64'd0 : 64'(e.beats));
            end
         end else if (rstn) begin
            chk("no_pulse", 64'(pulse[u]), 64'd0);
         end
      end
   end

   function automatic logic keep_legal(input logic [7:0] k);
      for (int n = 1; n <= 8; n++) begin
         if (k == 8'((1 << n) - 1)) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Present one beat at a negedge and wait (bounded) until it is accepted.
   task automatic beat(input int u, input logic [63:0] d, input logic [7:0] k, input logic l);
      int t = 0;
      tdata[u]  = d;
      tkeep[u]  = k;
      tlast[u]  = l;
      tvalid[u] = 1'b1;
      while (!ready[u] && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) chk("ready_timeout", 64'd0, 64'd1);
      @(negedge clk);
   endtask

   // Send an incrementing frame; bad_data flips bit 0 of that beat, bad_keep
   // sends 0x7F on that non-last beat. tvalid stays high afterwards.
   task automatic frame(input int u, input logic [63:0] seed, input int n, input int bad_data,
                        input int bad_keep, input logic [7:0] last_keep, input logic clr_last);
      logic err;
      err = (bad_data > 0) || (bad_keep >= 0) || !keep_legal(last_keep) ||
            (cfgb[u] != 16'd0 && int'(cfgb[u]) != n);
      for (int i = 0; i < n; i++) begin
         logic [63:0] d;
         logic [7:0]  k;
         d = seed + 64'(i);
         if (i == bad_data) d[0] = ~d[0];
         k = (i == n - 1) ? last_keep : ((i == bad_keep) ? 8'h7F : 8'hFF);
         m_bytes[u] += $countones(k);
         if (i == n - 1) begin
            sb.push_back('{u, err, 16'(n), clr_last});
            clr[u] = clr_last;
         end
         beat(u, d, k, i == n - 1);
      end
      clr[u] = 1'b0;
      m_frames[u]++;
      if (err) begin
         m_errs[u]++;
         m_sticky[u] = 1'b1;
      end
      if (clr_last) model_zero(u);
   endtask

   function automatic void model_zero(input int u);
      m_frames[u] = 0;
      m_errs[u]   = 0;
      m_bytes[u]  = 0;
      m_sticky[u] = 1'b0;
   endfunction

   task automatic idle(input int u);
      tvalid[u] = 1'b0;
      tlast[u]  = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic clear(input int u);
      clr[u] = 1'b1;
      @(negedge clk);
      clr[u] = 1'b0;
      model_zero(u);
   endtask

   task automatic stats(input int u);
      chk("frame_cnt", 64'(fcnt[u]), 64'(m_frames[u]));
      chk("err_frame_cnt", 64'(ecnt[u]), 64'(m_errs[u]));
      chk("byte_cnt", 64'(bcnt[u]), 64'(m_bytes[u]));
      chk("err_sticky", 64'(sticky[u]), 64'(m_sticky[u]));
   endtask

   initial begin
      int ones;
      int p;
      int t0;
      int g;
      rstn = 1'b0;
      for (int u = 0; u < 2; u++) begin
         en[u] = 1'b1; clr[u] = 1'b0; tdata[u] = '0; tkeep[u] = '0;
         tvalid[u] = 1'b0; tlast[u] = 1'b0;
      end
      cfgb[0] = 16'd16;
      cfgb[1] = 16'd12;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_tready0", 64'(ready[0]), 64'd0);
      chk("rst_tready1", 64'(ready[1]), 64'd0);
      chk("rst_lfb", 64'(lfb[0]), 64'd0);
      chk("rst_pulse", 64'(pulse[0]), 64'd0);
      stats(0);
      rstn = 1'b1;
      @(negedge clk);
      chk("tready_after_reset", 64'(ready[0]), 64'd1);

      // Throttle duty: 3 of every 4 cycles
      ones = 0;
      repeat (16) begin
         @(negedge clk);
         ones += int'(ready[1]);
      end
      chk("ready_duty", 64'(ones), 64'd12);

      // Three clean back-to-back 16-beat frames
      for (int f = 0; f < 3; f++) frame(0, 64'h100, 16, -1, -1, 8'hFF, 1'b0);
      idle(0);
      stats(0);

      // Data corruption in frame 2, beat 5
      clear(0);
      p = n_pulse[0];
      frame(0, 64'h100, 16, -1, -1, 8'hFF, 1'b0);
      frame(0, 64'h100, 16, 5, -1, 8'hFF, 1'b0);
      frame(0, 64'h100, 16, -1, -1, 8'hFF, 1'b0);
      idle(0);
      stats(0);
      chk("pulse_count", 64'(n_pulse[0] - p), 64'd1);

      // tkeep on 4-beat frames: legal partial, illegal last, illegal middle
      clear(0);
      cfgb[0] = 16'd4;
      frame(0, 64'h200, 4, -1, -1, 8'h0F, 1'b0);
      idle(0);
      stats(0);
      frame(0, 64'h300, 4, -1, -1, 8'hF0, 1'b0);
      idle(0);
      stats(0);
      frame(0, 64'h400, 4, -1, 1, 8'hFF, 1'b0);
      idle(0);
      stats(0);

      // Length check, then disabled
      clear(0);
      cfgb[0] = 16'd8;
      frame(0, 64'h500, 7, -1, -1, 8'hFF, 1'b0);
      idle(0);
      stats(0);
      cfgb[0] = 16'd0;
      frame(0, 64'h500, 7, -1, -1, 8'hFF, 1'b0);
      idle(0);
      stats(0);

      // stat_clear together with an errored tlast transfer
      cfgb[0] = 16'd5;
      frame(0, 64'h600, 4, -1, -1, 8'hFF, 1'b1);
      idle(0);
      stats(0);
      chk("clr_lfb", 64'(lfb[0]), 64'd0);

      // Throttled 12-beat frame, started on a low-ready phase
      g = 0;
      while (ready[1] && g < 10) begin
         @(negedge clk);
         g++;
      end
      t0 = cyc;
      frame(1, 64'h1000, 12, -1, -1, 8'hFF, 1'b0);
      chk("throttle_cycles", 64'(cyc - t0), 64'd16);

      // cfg_en pulsed low mid-frame
      t0 = cyc;
      fork
         begin
            repeat (6) @(negedge clk);
            en[1] = 1'b0;
            repeat (6) @(negedge clk);
            en[1] = 1'b1;
         end
      join_none
      frame(1, 64'h2000, 12, -1, -1, 8'hFF, 1'b0);
      chk("pause_stretched", 64'(cyc - t0 > 16), 64'd1);
      idle(1);
      stats(1);

      // Asynchronous reset mid-frame, then a fresh frame
      cfgb[0] = 16'd16;
      for (int i = 0; i < 5; i++) beat(0, 64'h900 + 64'(i), 8'hFF, 1'b0);
      rstn = 1'b0;
      tvalid[0] = 1'b0;
      #1;
      chk("arst_tready", 64'(ready[0]), 64'd0);
      chk("arst_frame_cnt1", 64'(fcnt[1]), 64'd0);
      chk("arst_byte_cnt1", 64'(bcnt[1]), 64'd0);
      model_zero(0);
      model_zero(1);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      frame(0, 64'hA00, 16, -1, -1, 8'hFF, 1'b0);
      idle(0);
      stats(0);
      chk("final_lfb", 64'(lfb[0]), 64'd16);

      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
